// File: rtl/capture_ctrl.sv
// capture_ctrl: capture sequencer between the LPC decoder and the ringbuffer
// write port. Filters 48-bit records by cycle type/direction and address
// window, runs arm -> trigger -> post-trigger capture, and counts records lost
// while the ringbuffer reports overflow.
// Optional build macro: CAPTURE_MARKER_EN. When defined, a loss-marker record
// is injected once the overflow clears.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no writes, waiting for arm
// ARMED    | no writes, waiting for a matching record at the trigger addr
// CAPTURE  | every matching record is written, counting down remaining
// DONE     | post-trigger count exhausted, no writes until re-armed
module capture_ctrl #(
  parameter int DW    = 48,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic             cfg_arm,
  input  logic             cfg_stop,
  input  logic [15:0]      cfg_cyc_mask,
  input  logic [31:0]      cfg_addr_lo,
  input  logic [31:0]      cfg_addr_hi,
  input  logic [31:0]      cfg_trig_addr,
  input  logic [CNT_W-1:0] cfg_post_count,
  input  logic             buf_overflow,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic [1:0]       state,
  output logic             triggered,
  output logic [15:0]      drop_total
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt, w_eval_state;
  logic [CNT_W-1:0]  r_remaining, w_remaining_nxt;
  logic              r_unlimited, w_unlimited_nxt;
  logic [15:0]       r_drop_total;
  logic              r_out_valid;
  logic [DW-1:0]     r_out_data;

  logic [31:0]       w_addr;
  logic              w_match;
  logic              w_take;
  logic              w_write;
  logic              w_drop;
  logic              w_arm_eff;
  logic              w_marker_emit;
  logic [DW-1:0]     w_marker_data;

  assign w_addr    = in_data[47:16];
  assign w_match   = in_valid & cfg_cyc_mask[in_data[3:0]] &
                     (w_addr >= cfg_addr_lo) & (w_addr <= cfg_addr_hi);
  assign w_arm_eff = cfg_arm & ~cfg_stop;
  assign w_write   = w_take & ~buf_overflow;
  assign w_drop    = w_take & buf_overflow;

  // Next-state logic; a same-cycle record is judged against the state the
  // control pulses would produce (stop wins, arm makes it a trigger candidate).
  always_comb begin
    w_eval_state    = r_state;
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_unlimited_nxt = r_unlimited;
    w_take          = 1'b0;
    if (cfg_stop) begin
      w_eval_state = ST_IDLE;
    end else if (cfg_arm) begin
      w_eval_state    = ST_ARMED;
      w_remaining_nxt = cfg_post_count;
    end
    w_state_nxt = w_eval_state;
    case (w_eval_state)
      ST_ARMED: begin
        if (w_match && (w_addr == cfg_trig_addr)) begin
          w_take          = 1'b1;
          w_unlimited_nxt = (cfg_post_count == '0);
          w_remaining_nxt = cfg_post_count - CNT_W'(1);
          w_state_nxt     = (cfg_post_count == CNT_W'(1)) ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (w_match) begin
          w_take = 1'b1;
          if (!r_unlimited) begin
            w_remaining_nxt = r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              w_state_nxt = ST_DONE;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // State and post-trigger counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_unlimited <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_unlimited <= w_unlimited_nxt;
    end
  end

  // Saturating lost-record counter, cleared by an effective arm.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_drop_total <= '0;
    end else if (w_arm_eff) begin
      r_drop_total <= w_drop ? 16'd1 : 16'd0;
    end else if (w_drop && (r_drop_total != 16'hFFFF)) begin
      r_drop_total <= r_drop_total + 16'd1;
    end
  end

`ifdef CAPTURE_MARKER_EN
  logic        r_ovf_d;
  logic        r_marker_pending;
  logic [15:0] r_drop_since_marker;

  assign w_marker_emit = r_marker_pending & ~w_write & ~buf_overflow;
  assign w_marker_data = DW'({16'h0, r_drop_since_marker, 8'h00, 4'hF, 4'h0});

  // Track losses since the last marker and arm a marker on overflow release.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovf_d             <= 1'b0;
      r_marker_pending    <= 1'b0;
      r_drop_since_marker <= '0;
    end else begin
      r_ovf_d <= buf_overflow;
      if (w_marker_emit) begin
        r_marker_pending    <= 1'b0;
        r_drop_since_marker <= '0;
      end else begin
        if (w_drop && (r_drop_since_marker != 16'hFFFF)) begin
          r_drop_since_marker <= r_drop_since_marker + 16'd1;
        end
        if (r_ovf_d && !buf_overflow && (r_drop_since_marker != 16'h0)) begin
          r_marker_pending <= 1'b1;
        end
      end
    end
  end
`else
  assign w_marker_emit = 1'b0;
  assign w_marker_data = '0;
`endif

  // Registered write port; a real record always beats a pending marker.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_write | w_marker_emit;
      if (w_write) begin
        r_out_data <= in_data;
      end else if (w_marker_emit) begin
        r_out_data <= w_marker_data;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign state      = r_state;
  assign triggered  = (r_state == ST_CAPTURE) | (r_state == ST_DONE);
  assign drop_total = r_drop_total;

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: directed scenarios followed by random
// traffic, checked against a cycle-level behavioural model of the sequencer.
module tb_capture_ctrl;
  localparam int DW    = 48;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic             cfg_arm, cfg_stop;
  logic [15:0]      cfg_cyc_mask;
  logic [31:0]      cfg_addr_lo, cfg_addr_hi, cfg_trig_addr;
  logic [CNT_W-1:0] cfg_post_count;
  logic             buf_overflow;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic [1:0]       state;
  logic             triggered;
  logic [15:0]      drop_total;

  capture_ctrl #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .cfg_arm(cfg_arm), .cfg_stop(cfg_stop), .cfg_cyc_mask(cfg_cyc_mask),
    .cfg_addr_lo(cfg_addr_lo), .cfg_addr_hi(cfg_addr_hi),
    .cfg_trig_addr(cfg_trig_addr), .cfg_post_count(cfg_post_count),
    .buf_overflow(buf_overflow), .out_valid(out_valid), .out_data(out_data),
    .state(state), .triggered(triggered), .drop_total(drop_total)
  );

  always #5 clock = ~clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  bit          run     = 0;
  int          n_writes = 0;
  logic [47:0] last_wdata = '0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {int unsigned cyc; logic [47:0] data;} exp_t;
  exp_t sb[$];

  // Pending configuration, applied at the start of the next stepped cycle.
  logic [15:0] t_mask = 16'hFFFF;
  logic [31:0] t_lo = 32'h0, t_hi = 32'hFFFF_FFFF, t_trig = 32'h80;
  logic [15:0] t_post = 16'd0;

  // Reference model: sequencer mode 0..3, records left, loss bookkeeping.
  int     m_mode = 0;
  longint m_left = 0;
  bit     m_unlim = 0;
  int     m_drops = 0;
  int     m_sm = 0;
  bit     m_pend = 0;
  bit     m_prev_ovf = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit rec_match(logic [47:0] d);
    longint a;
    a = longint'(d[47:16]);
    return cfg_cyc_mask[d[3:0]] && (a >= longint'(cfg_addr_lo)) &&
           (a <= longint'(cfg_addr_hi));
  endfunction

  function automatic logic [47:0] rec(logic [31:0] addr, logic [7:0] dat, logic [3:0] ct);
    return {addr, dat, 4'h0, ct};
  endfunction

  // One clock of stimulus: check status from the previous cycle, drive, model.
  task automatic step(bit v, logic [47:0] d, bit arm, bit stp, bit ovf);
    bit take;
    bit wrote;
    @(negedge clock);
    chk("state", state, m_mode);
    chk("triggered", triggered, m_mode >= 2);
    chk("drop_total", drop_total, m_drops);
    cfg_cyc_mask = t_mask; cfg_addr_lo = t_lo; cfg_addr_hi = t_hi;
    cfg_trig_addr = t_trig; cfg_post_count = t_post;
    in_valid = v; in_data = d; cfg_arm = arm; cfg_stop = stp; buf_overflow = ovf;
    take = 0;
    wrote = 0;
    if (stp) m_mode = 0;
    else if (arm) begin m_mode = 1; m_drops = 0; end
    if (v && rec_match(d)) begin
      if (m_mode == 1 && d[47:16] == cfg_trig_addr) begin
        take = 1;
        if (cfg_post_count == 0) begin m_unlim = 1; m_mode = 2; end
        else begin
          m_unlim = 0;
          m_left = longint'(cfg_post_count) - 1;
          m_mode = (m_left == 0) ? 3 : 2;
        end
      end else if (m_mode == 2) begin
        take = 1;
        if (!m_unlim) begin
          m_left--;
          if (m_left == 0) m_mode = 3;
        end
      end
    end
    if (take) begin
      if (ovf) begin
        if (m_drops < 65535) m_drops++;
        if (m_sm < 65535) m_sm++;
      end else begin
        sb.push_back('{cyc + 1, d});
        wrote = 1;
      end
    end
`ifdef CAPTURE_MARKER_EN
    if (m_pend && !wrote && !ovf) begin
      sb.push_back('{cyc + 1, {16'h0, 16'(m_sm), 8'h00, 4'hF, 4'h0}});
      m_sm = 0;
      m_pend = 0;
    end
    if (m_prev_ovf && !ovf && m_sm != 0) m_pend = 1;
    m_prev_ovf = ovf;
`endif
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0);
  endtask

  // Monitor: every write must match the head of the scoreboard in data and cycle.
  always @(negedge clock) begin
    if (run) begin
      if (out_valid) begin
        n_writes++;
        last_wdata = out_data;
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_write: got %h expected no write (cycle %0d)", out_data, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          n_tests++;
          if (e.cyc != cyc || e.data !== out_data) begin
            n_fail++;
            $display("FAIL write: got %h at cycle %0d expected %h at cycle %0d",
                     out_data, cyc, e.data, e.cyc);
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        n_tests++; n_fail++;
        $display("FAIL missing_write: got no write at cycle %0d expected %h", cyc, e.data);
      end
    end
  end

  initial begin
    int w0;
    bit t_ovf;
    reset = 1; in_valid = 0; in_data = '0; cfg_arm = 0; cfg_stop = 0;
    buf_overflow = 0; cfg_cyc_mask = 16'hFFFF; cfg_addr_lo = 0;
    cfg_addr_hi = 32'hFFFF_FFFF; cfg_trig_addr = 32'h80; cfg_post_count = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_state", state, 0);
    chk("rst_triggered", triggered, 0);
    chk("rst_drop_total", drop_total, 0);
    reset = 0;
    run = 1;

    // Not armed: nothing is written.
    w0 = n_writes;
    for (int i = 0; i < 5; i++) step(1, rec(32'h80 + i, 8'(i), 4'h0), 0, 0, 0);
    idle(2);
    chk("t1_no_writes", n_writes - w0, 0);

    // Arm, trigger at 0x80, three records captured.
    t_trig = 32'h80; t_post = 16'd3;
    step(0, '0, 1, 0, 0);
    w0 = n_writes;
    step(1, rec(32'h10, 8'h11, 4'h1), 0, 0, 0);
    step(1, rec(32'h80, 8'h22, 4'h1), 0, 0, 0);
    step(1, rec(32'h84, 8'h33, 4'h1), 0, 0, 0);
    step(1, rec(32'h88, 8'h44, 4'h1), 0, 0, 0);
    step(1, rec(32'h8C, 8'h55, 4'h1), 0, 0, 0);
    idle(1);
    chk("t2_state_done", state, 3);
    chk("t2_triggered", triggered, 1);
    idle(1);
    chk("t2_write_count", n_writes - w0, 3);

    // Window and cycle-type filtering.
    t_mask = 16'h0001; t_lo = 32'h60; t_hi = 32'h6F; t_trig = 32'h64; t_post = 16'd0;
    step(0, '0, 1, 0, 0);
    w0 = n_writes;
    step(1, rec(32'h64, 8'hA5, 4'h0), 0, 0, 0);
    step(1, rec(32'h70, 8'hA6, 4'h0), 0, 0, 0);
    step(1, rec(32'h64, 8'hA7, 4'h2), 0, 0, 0);
    idle(2);
    chk("t3_write_count", n_writes - w0, 1);

    // Overflow drops in unlimited capture, then marker on release.
    t_mask = 16'hFFFF; t_lo = 32'h0; t_hi = 32'hFFFF_FFFF;
    w0 = n_writes;
    for (int i = 0; i < 4; i++) step(1, rec(32'h200 + 4 * i, 8'(i), 4'h1), 0, 0, 1);
    idle(3);
    chk("t4_drop_total", drop_total, 4);
`ifdef CAPTURE_MARKER_EN
    chk("t4_marker", last_wdata, 48'h0000_0004_00F0);
    chk("t4_write_count", n_writes - w0, 1);
`else
    chk("t4_write_count", n_writes - w0, 0);
`endif

    // Marker pending collides with a real record: record first.
    for (int i = 0; i < 2; i++) step(1, rec(32'h300, 8'(i), 4'h1), 0, 0, 1);
    step(0, '0, 0, 0, 0);
    step(1, rec(32'h304, 8'h77, 4'h1), 0, 0, 0);
    idle(3);
`ifdef CAPTURE_MARKER_EN
    chk("t5_marker", last_wdata, 48'h0000_0002_00F0);
`else
    chk("t5_record", last_wdata, rec(32'h304, 8'h77, 4'h1));
`endif

    // Arm and stop together with a trigger record present.
    t_trig = 32'h80; t_post = 16'd2;
    step(0, '0, 1, 0, 0);
    w0 = n_writes;
    step(1, rec(32'h80, 8'h99, 4'h1), 1, 1, 0);
    idle(2);
    chk("t6_state_idle", state, 0);
    chk("t6_no_write", n_writes - w0, 0);

    // Random traffic.
    t_ovf = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 199) == 0) begin
        t_mask = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
        case ($urandom_range(0, 3))
          0: begin t_lo = 32'h0;  t_hi = 32'hFFFF_FFFF; end
          1: begin t_lo = 32'h60; t_hi = 32'h6F; end
          2: begin t_lo = 32'h70; t_hi = 32'h60; end
          default: begin t_lo = 32'h10; t_hi = 32'h90; end
        endcase
        case ($urandom_range(0, 2))
          0: t_trig = 32'h80;
          1: t_trig = 32'h64;
          default: t_trig = 32'h10;
        endcase
        case ($urandom_range(0, 4))
          0: t_post = 16'd0;
          1: t_post = 16'd1;
          2: t_post = 16'd2;
          3: t_post = 16'd3;
          default: t_post = 16'd7;
        endcase
      end
      case ($urandom_range(0, 5))
        0: a = 32'h80;
        1: a = 32'h64;
        2: a = 32'h10;
        3: a = 32'h60 + $urandom_range(0, 31);
        4: a = t_trig;
        default: a = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) t_ovf = ~t_ovf;
      step($urandom_range(0, 9) < 6, rec(a, 8'($urandom), 4'($urandom_range(0, 15))),
           $urandom_range(0, 29) == 0, $urandom_range(0, 89) == 0, t_ovf);
    end
    idle(5);
    chk("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
